// File: rtl/cosim_cmd_engine.sv
// -----------------------------------------------------------------------------
// cosim_cmd_engine
//
// Byte-stream command engine between a byte transport (valid/ready, e.g. UART)
// and an array of NoC traffic loaders. It decodes host commands, drives
// per-core loader configuration, starts the loaders, polls their idle state,
// reads PMU counters back, and applies a timed NoC reset. Each command gets
// an ack, error or data response.
//
// Commands (opcode, args -> response):
//   0x01 CFG       core, id, flags, axlen -> 0xA1 (0xEE if core out of range)
//   0x02 START     -                      -> 0xA2
//   0x03 POLL      -                      -> ceil(CORE_COUNT/8) idle bytes, LSB first
//   0x04 PMU       core, addr             -> PMU_DATA_WIDTH/8 bytes, little-endian
//   0x05 NOC_RESET -                      -> 0xA5 after RESET_CYCLES of noc_rst_o
//   other          -                      -> 0xEE
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   rx_data_i/valid_i/ready_o  command byte input
//   tx_data_o/valid_o/ready_i  response byte output
//   pmu_addr_o / pmu_data_i    per-core PMU counter select and value
//   resp_wait_o, write_o,
//   id_o, axlen_o              per-core loader configuration
//   fifo_push_o                one-hot 1-cycle push of the config into a core FIFO
//   start_o                    1-cycle start pulse to all loaders
//   idle_i                     per-core loader idle
//   noc_rst_o                  active-high reset to NoC and loaders
//
// Optional feature macro: COSIM_TIMEOUT_EN
//   When defined, a partially received command is abandoned after
//   TIMEOUT_CYCLES cycles without an rx byte and 0xEF is returned.
//   When undefined, argument collection waits indefinitely.
// -----------------------------------------------------------------------------
module cosim_cmd_engine #(
   parameter int unsigned CORE_COUNT     = 16,
   parameter int unsigned AXI_ID_WIDTH   = 5,
   parameter int unsigned PMU_ADDR_WIDTH = 5,
   parameter int unsigned PMU_DATA_WIDTH = 32,
   parameter int unsigned RESET_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [7:0]                           rx_data_i,
   input  logic                                 rx_valid_i,
   output logic                                 rx_ready_o,
   output logic [7:0]                           tx_data_o,
   output logic                                 tx_valid_o,
   input  logic                                 tx_ready_i,
   output logic [CORE_COUNT*PMU_ADDR_WIDTH-1:0] pmu_addr_o,
   input  logic [CORE_COUNT*PMU_DATA_WIDTH-1:0] pmu_data_i,
   output logic [CORE_COUNT-1:0]                resp_wait_o,
   output logic [CORE_COUNT-1:0]                write_o,
   output logic [CORE_COUNT*AXI_ID_WIDTH-1:0]   id_o,
   output logic [CORE_COUNT*8-1:0]              axlen_o,
   output logic [CORE_COUNT-1:0]                fifo_push_o,
   output logic                                 start_o,
   input  logic [CORE_COUNT-1:0]                idle_i,
   output logic                                 noc_rst_o
);

   localparam int unsigned POLL_BYTES = (CORE_COUNT + 7) / 8;
   localparam int unsigned PMU_BYTES  = PMU_DATA_WIDTH / 8;
   localparam int unsigned RESP_BYTES = (POLL_BYTES > PMU_BYTES) ? POLL_BYTES : PMU_BYTES;
   localparam int unsigned RESP_W     = RESP_BYTES * 8;

   localparam logic [7:0] OP_CFG   = 8'h01;
   localparam logic [7:0] OP_START = 8'h02;
   localparam logic [7:0] OP_POLL  = 8'h03;
   localparam logic [7:0] OP_PMU   = 8'h04;
   localparam logic [7:0] OP_NRST  = 8'h05;

   localparam logic [7:0] RSP_CFG   = 8'hA1;
   localparam logic [7:0] RSP_START = 8'hA2;
   localparam logic [7:0] RSP_NRST  = 8'hA5;
   localparam logic [7:0] RSP_ERR   = 8'hEE;

   typedef enum logic [2:0] {
      StIdle,
      StArgs,
      StExec,
      StNrst,
      StResp
   } state_e;

   state_e                             r_state;
   state_e                             w_state_nxt;

   // High while rst_i is applied and for the edge after; gates rx and holds the NoC in reset.
   logic                               r_por;
   logic [7:0]                         r_opcode;
   logic [7:0]                         r_args [4];
   logic [1:0]                         r_arg_idx;
   logic [31:0]                        r_rst_cnt;

   // Response bytes are shifted out LSB first; r_resp_cnt counts bytes still to send.
   logic [RESP_W-1:0]                  r_resp;
   logic [5:0]                         r_resp_cnt;

   logic [CORE_COUNT*AXI_ID_WIDTH-1:0]   r_id;
   logic [CORE_COUNT-1:0]                r_write;
   logic [CORE_COUNT-1:0]                r_resp_wait;
   logic [CORE_COUNT*8-1:0]              r_axlen;
   logic [CORE_COUNT*PMU_ADDR_WIDTH-1:0] r_pmu_addr;
   logic [CORE_COUNT-1:0]                r_fifo_push;
   logic                                 r_start;

`ifdef COSIM_TIMEOUT_EN
   logic [31:0]                        r_to_cnt;
   logic                               w_to_hit;
`endif

   logic                               w_rx_fire;
   logic                               w_tx_fire;
   logic                               w_args_last;
   logic                               w_core_ok;
   logic                               w_nrst_done;
   logic                               w_resp_last;
   logic [PMU_DATA_WIDTH-1:0]          w_pmu_sel;

   assign w_rx_fire   = rx_valid_i & rx_ready_o;
   assign w_tx_fire   = tx_valid_o & tx_ready_i;
   // CFG carries four argument bytes, PMU two.
   assign w_args_last = (r_arg_idx == ((r_opcode == OP_CFG) ? 2'd3 : 2'd1));
   // Core byte is compared in 9 bits so CORE_COUNT=256 accepts every byte value.
   assign w_core_ok   = ({1'b0, r_args[0]} < 9'(CORE_COUNT));
   assign w_nrst_done = (r_rst_cnt == 32'(RESET_CYCLES - 1));
   assign w_resp_last = (r_resp_cnt == 6'd1);

`ifdef COSIM_TIMEOUT_EN
   assign w_to_hit = (r_state == StArgs) && !w_rx_fire &&
                     (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
`endif

   // PMU value of the addressed core; only used when the core is in range.
   always_comb begin
      w_pmu_sel = '0;
      for (int k = 0; k < CORE_COUNT; k++) begin
         if (r_args[0] == 8'(k)) begin
            w_pmu_sel = pmu_data_i[k*PMU_DATA_WIDTH +: PMU_DATA_WIDTH];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle: begin
            if (w_rx_fire) begin
               case (rx_data_i)
                  OP_CFG, OP_PMU: w_state_nxt = StArgs;
                  OP_NRST:        w_state_nxt = StNrst;
                  // Argument-less and unknown opcodes resolve in EXEC.
                  default:        w_state_nxt = StExec;
               endcase
            end
         end
         StArgs: begin
            if (w_rx_fire && w_args_last) begin
               w_state_nxt = StExec;
            end
`ifdef COSIM_TIMEOUT_EN
            else if (w_to_hit) begin
               w_state_nxt = StResp;
            end
`endif
         end
         StExec: w_state_nxt = StResp;
         StNrst: begin
            if (w_nrst_done) begin
               w_state_nxt = StResp;
            end
         end
         StResp: begin
            if (w_tx_fire && w_resp_last) begin
               w_state_nxt = StIdle;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      rx_ready_o = !r_por && ((r_state == StIdle) || (r_state == StArgs));
      tx_valid_o = (r_state == StResp);
      tx_data_o  = r_resp[7:0];
      noc_rst_o  = r_por || (r_state == StNrst);
   end

   assign pmu_addr_o  = r_pmu_addr;
   assign resp_wait_o = r_resp_wait;
   assign write_o     = r_write;
   assign id_o        = r_id;
   assign axlen_o     = r_axlen;
   assign fifo_push_o = r_fifo_push;
   assign start_o     = r_start;

   // ---------------------------------------------------------------------------
   // Datapath: argument capture, command execution, response shifting
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_por       <= 1'b1;
         r_opcode    <= '0;
         for (int i = 0; i < 4; i++) begin
            r_args[i] <= '0;
         end
         r_arg_idx   <= '0;
         r_rst_cnt   <= '0;
         r_resp      <= '0;
         r_resp_cnt  <= '0;
         r_id        <= '0;
         r_write     <= '0;
         r_resp_wait <= '0;
         r_axlen     <= '0;
         r_pmu_addr  <= '0;
         r_fifo_push <= '0;
         r_start     <= 1'b0;
`ifdef COSIM_TIMEOUT_EN
         r_to_cnt    <= '0;
`endif
      end else begin
         r_por       <= 1'b0;
         r_fifo_push <= '0;
         r_start     <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (w_rx_fire) begin
                  r_opcode  <= rx_data_i;
                  r_arg_idx <= '0;
                  r_rst_cnt <= '0;
`ifdef COSIM_TIMEOUT_EN
                  r_to_cnt  <= '0;
`endif
               end
            end
            StArgs: begin
               if (w_rx_fire) begin
                  r_args[r_arg_idx] <= rx_data_i;
                  r_arg_idx         <= r_arg_idx + 2'd1;
                  // The PMU select is driven as soon as the addr byte lands so
                  // the counter value is settled by the end of EXEC.
                  if ((r_opcode == OP_PMU) && (r_arg_idx == 2'd1)) begin
                     for (int k = 0; k < CORE_COUNT; k++) begin
                        if (r_args[0] == 8'(k)) begin
                           r_pmu_addr[k*PMU_ADDR_WIDTH +: PMU_ADDR_WIDTH] <=
                              rx_data_i[PMU_ADDR_WIDTH-1:0];
                        end
                     end
                  end
`ifdef COSIM_TIMEOUT_EN
                  r_to_cnt <= '0;
`endif
               end
`ifdef COSIM_TIMEOUT_EN
               else if (w_to_hit) begin
                  r_resp     <= RESP_W'(8'hEF);
                  r_resp_cnt <= 6'd1;
               end else begin
                  r_to_cnt <= r_to_cnt + 32'd1;
               end
`endif
            end
            StExec: begin
               r_resp     <= RESP_W'(RSP_ERR);
               r_resp_cnt <= 6'd1;
               case (r_opcode)
                  OP_CFG: begin
                     if (w_core_ok) begin
                        r_resp <= RESP_W'(RSP_CFG);
                        for (int k = 0; k < CORE_COUNT; k++) begin
                           if (r_args[0] == 8'(k)) begin
                              r_id[k*AXI_ID_WIDTH +: AXI_ID_WIDTH] <=
                                 r_args[1][AXI_ID_WIDTH-1:0];
                              r_write[k]         <= r_args[2][0];
                              r_resp_wait[k]     <= r_args[2][1];
                              r_axlen[k*8 +: 8]  <= r_args[3];
                              r_fifo_push[k]     <= 1'b1;
                           end
                        end
                     end
                  end
                  OP_START: begin
                     r_start <= 1'b1;
                     r_resp  <= RESP_W'(RSP_START);
                  end
                  OP_POLL: begin
                     r_resp     <= RESP_W'(idle_i);
                     r_resp_cnt <= 6'(POLL_BYTES);
                  end
                  OP_PMU: begin
                     if (w_core_ok) begin
                        r_resp     <= RESP_W'(w_pmu_sel);
                        r_resp_cnt <= 6'(PMU_BYTES);
                     end
                  end
                  default: ;
               endcase
            end
            StNrst: begin
               r_rst_cnt <= r_rst_cnt + 32'd1;
               if (w_nrst_done) begin
                  r_resp     <= RESP_W'(RSP_NRST);
                  r_resp_cnt <= 6'd1;
               end
            end
            StResp: begin
               if (w_tx_fire) begin
                  r_resp     <= r_resp >> 8;
                  r_resp_cnt <= r_resp_cnt - 6'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cosim_cmd_engine.sv
module tb_cosim_cmd_engine;

   localparam int unsigned NC = 16;
   localparam int unsigned AW = 5;
   localparam int unsigned PW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned RC = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [NC*PW-1:0]  pmu_addr;
   logic [NC*DW-1:0]  pmu_data;
   logic [NC-1:0]     resp_wait;
   logic [NC-1:0]     write_v;
   logic [NC*AW-1:0]  id;
   logic [NC*8-1:0]   axlen;
   logic [NC-1:0]     fifo_push;
   logic              start;
   logic [NC-1:0]     idle;
   logic              noc_rst;

   always #5 clk = ~clk;

   cosim_cmd_engine #(
      .CORE_COUNT     (NC),
      .AXI_ID_WIDTH   (AW),
      .PMU_ADDR_WIDTH (PW),
      .PMU_DATA_WIDTH (DW),
      .RESET_CYCLES   (RC),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .rx_data_i   (rx_data),
      .rx_valid_i  (rx_valid),
      .rx_ready_o  (rx_ready),
      .tx_data_o   (tx_data),
      .tx_valid_o  (tx_valid),
      .tx_ready_i  (tx_ready),
      .pmu_addr_o  (pmu_addr),
      .pmu_data_i  (pmu_data),
      .resp_wait_o (resp_wait),
      .write_o     (write_v),
      .id_o        (id),
      .axlen_o     (axlen),
      .fifo_push_o (fifo_push),
      .start_o     (start),
      .idle_i      (idle),
      .noc_rst_o   (noc_rst)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference model of the loader configuration seen by the host.
   logic [AW-1:0] m_id    [NC];
   logic          m_wr    [NC];
   logic          m_rw    [NC];
   logic [7:0]    m_len   [NC];
   logic [PW-1:0] m_paddr [NC];
   logic [DW-1:0] m_pmu   [NC];

   logic [7:0]    cmd_q [$];
   logic [7:0]    exp_q [$];
   logic [7:0]    got_q [$];
   logic [NC-1:0] exp_push;
   int            exp_start;

   // Observed side effects, sampled on the falling edge.
   int            push_seen, start_seen, nrst_hi;
   logic [NC-1:0] last_push;
   logic [AW-1:0] cap_id;
   logic          cap_wr, cap_rw;
   logic [7:0]    cap_len;

   always @(negedge clk) begin
      if (noc_rst) nrst_hi++;
      if (start) start_seen++;
      if (fifo_push != '0) begin
         push_seen++;
         last_push = fifo_push;
         for (int k = 0; k < NC; k++) begin
            if (fifo_push[k]) begin
               cap_id  = id[k*AW +: AW];
               cap_wr  = write_v[k];
               cap_rw  = resp_wait[k];
               cap_len = axlen[k*8 +: 8];
            end
         end
      end
   end

   task automatic model_reset();
      for (int k = 0; k < NC; k++) begin
         m_id[k] = '0; m_wr[k] = 1'b0; m_rw[k] = 1'b0; m_len[k] = '0; m_paddr[k] = '0;
      end
   endtask

   task automatic apply_pmu();
      for (int k = 0; k < NC; k++) pmu_data[k*DW +: DW] = m_pmu[k];
   endtask

   // Expected response and side effects of the command in cmd_q.
   task automatic model_cmd();
      int c;
      exp_q.delete();
      exp_push  = '0;
      exp_start = 0;
      case (cmd_q[0])
         8'h01: begin
            c = int'(cmd_q[1]);
            if (c < NC) begin
               m_id[c]  = cmd_q[2][AW-1:0];
               m_wr[c]  = cmd_q[3][0];
               m_rw[c]  = cmd_q[3][1];
               m_len[c] = cmd_q[4];
               exp_push[c] = 1'b1;
               exp_q.push_back(8'hA1);
            end else exp_q.push_back(8'hEE);
         end
         8'h02: begin exp_start = 1; exp_q.push_back(8'hA2); end
         8'h03: for (int b = 0; b < (NC + 7) / 8; b++) exp_q.push_back(idle[b*8 +: 8]);
         8'h04: begin
            c = int'(cmd_q[1]);
            if (c < NC) begin
               m_paddr[c] = cmd_q[2][PW-1:0];
               for (int b = 0; b < DW / 8; b++) exp_q.push_back(m_pmu[c][b*8 +: 8]);
            end else exp_q.push_back(8'hEE);
         end
         8'h05:   exp_q.push_back(8'hA5);
         default: exp_q.push_back(8'hEE);
      endcase
   endtask

   // Called just after a falling edge; returns just after the falling edge following the fire.
   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && t < 100) begin @(negedge clk); t++; end
      if (!rx_ready) check("rx_accept_timeout", rx_ready, 1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // stall < 0: random 0..3 not-ready cycles per byte; otherwise that many.
   task automatic recv(input int n, input int stall);
      int t, k;
      logic [7:0] d;
      got_q.delete();
      for (int i = 0; i < n; i++) begin
         if (i > 0) check("tx_back_to_back", tx_valid, 1);
         t = 0;
         while (!tx_valid && t < 300) begin @(negedge clk); t++; end
         if (!tx_valid) begin
            check("tx_valid_timeout", tx_valid, 1);
            tx_ready = 1'b0;
            return;
         end
         d = tx_data;
         k = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
         if (k > 0) begin
            tx_ready = 1'b0;
            repeat (k) begin
               @(negedge clk);
               check("tx_hold_valid", tx_valid, 1);
               check("tx_hold_data", tx_data, d);
            end
         end
         tx_ready = 1'b1;
         @(negedge clk);
         got_q.push_back(d);
      end
      tx_ready = 1'b0;
   endtask

   task automatic run_cmd(input int stall);
      int c;
      model_cmd();
      push_seen  = 0;
      start_seen = 0;
      nrst_hi    = 0;
      foreach (cmd_q[i]) send_byte(cmd_q[i]);
      recv(exp_q.size(), stall);
      check("resp_len", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("resp_byte%0d_op%0h", i, cmd_q[0]), got_q[i], exp_q[i]);
      check("tx_valid_after", tx_valid, 0);
      check("rx_ready_after", rx_ready, 1);
      check("push_cycles", push_seen, (exp_push != '0) ? 1 : 0);
      check("start_cycles", start_seen, exp_start);
      check("nrst_cycles", nrst_hi, (cmd_q[0] == 8'h05) ? RC : 0);
      if (exp_push != '0) begin
         c = int'(cmd_q[1]);
         check("push_vec", last_push, exp_push);
         check("push_id", cap_id, m_id[c]);
         check("push_write", cap_wr, m_wr[c]);
         check("push_resp_wait", cap_rw, m_rw[c]);
         check("push_axlen", cap_len, m_len[c]);
      end
      if (cmd_q[0] == 8'h04 && int'(cmd_q[1]) < NC) begin
         c = int'(cmd_q[1]);
         check("pmu_addr", pmu_addr[c*PW +: PW], m_paddr[c]);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_noc_rst", noc_rst, 1);
      check("rst_fifo_push", fifo_push, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_rx_ready", rx_ready, 0);
      check("rst_start", start, 0);
      check("rst_id", id, 0);
      rst = 1'b0;
      @(negedge clk);
      check("rx_ready_after_rst", rx_ready, 1);
      model_reset();
   endtask

   initial begin
      int sel, t;
      rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0; idle = '0; pmu_data = '0;
      for (int k = 0; k < NC; k++) m_pmu[k] = $urandom;
      apply_pmu();
      do_reset();

      // Directed CFG of core 3.
      cmd_q = '{8'h01, 8'h03, 8'h1A, 8'h03, 8'h0F};
      run_cmd(0);
      check("cfg_push_core3", last_push, 16'h0008);
      check("cfg_id3", id[3*AW +: AW], 5'h1A);
      check("cfg_write3", write_v[3], 1);
      check("cfg_resp_wait3", resp_wait[3], 1);
      check("cfg_axlen3", axlen[3*8 +: 8], 8'h0F);

      // POLL, back-to-back then with a 3-cycle stall per byte.
      idle  = 16'hA55A;
      cmd_q = '{8'h03};
      run_cmd(0);
      run_cmd(3);

      // PMU readback of core 7.
      m_pmu[7] = 32'h12345678;
      apply_pmu();
      cmd_q = '{8'h04, 8'h07, 8'h02};
      run_cmd(-1);
      check("pmu_addr7", pmu_addr[7*PW +: PW], 5'd2);

      // Errors: out-of-range core, unknown opcode.
      cmd_q = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00};
      run_cmd(-1);
      cmd_q = '{8'h7F};
      run_cmd(-1);

      // Timed NoC reset, then START; config must survive the NoC reset.
      cmd_q = '{8'h05};
      run_cmd(-1);
      check("cfg_kept_after_nrst", id[3*AW +: AW], 5'h1A);
      cmd_q = '{8'h02};
      run_cmd(-1);

      // Reset in the middle of a command: partial CFG is dropped.
      send_byte(8'h01);
      send_byte(8'h05);
      do_reset();
      check("cfg_cleared_by_rst", id[3*AW +: AW], 0);
      cmd_q = '{8'h02};
      run_cmd(-1);

      // Reset in the middle of a response: pending bytes are dropped.
      idle = 16'hFFFF;
      send_byte(8'h03);
      t = 0;
      while (!tx_valid && t < 50) begin @(negedge clk); t++; end
      check("mid_resp_valid", tx_valid, 1);
      do_reset();
      cmd_q = '{8'h02};
      run_cmd(-1);

      // Randomized command mix.
      for (int it = 0; it < 60; it++) begin
         sel  = int'($urandom_range(0, 6));
         idle = NC'($urandom);
         for (int k = 0; k < NC; k++) m_pmu[k] = $urandom;
         apply_pmu();
         cmd_q.delete();
         case (sel)
            0, 5: begin
               cmd_q.push_back(8'h01);
               if (sel == 5) cmd_q.push_back(8'($urandom_range(NC, 255)));
               else cmd_q.push_back(8'($urandom_range(0, NC - 1)));
               cmd_q.push_back(8'($urandom));
               cmd_q.push_back(8'($urandom));
               cmd_q.push_back(8'($urandom));
            end
            1: cmd_q.push_back(8'h02);
            2: cmd_q.push_back(8'h03);
            3: begin
               cmd_q.push_back(8'h04);
               cmd_q.push_back(8'($urandom_range(0, NC + 1)));
               cmd_q.push_back(8'($urandom));
            end
            4: cmd_q.push_back(8'($urandom_range(6, 255)));
            default: cmd_q.push_back(8'h05);
         endcase
         run_cmd(-1);
      end

      // Every core's configuration must match the model.
      for (int k = 0; k < NC; k++) begin
         check($sformatf("final_id%0d", k), id[k*AW +: AW], m_id[k]);
         check($sformatf("final_write%0d", k), write_v[k], m_wr[k]);
         check($sformatf("final_resp_wait%0d", k), resp_wait[k], m_rw[k]);
         check($sformatf("final_axlen%0d", k), axlen[k*8 +: 8], m_len[k]);
         check($sformatf("final_pmu_addr%0d", k), pmu_addr[k*PW +: PW], m_paddr[k]);
      end

`ifdef COSIM_TIMEOUT_EN
      push_seen = 0;
      send_byte(8'h01);
      send_byte(8'h02);
      recv(1, 0);
      check("timeout_len", got_q.size(), 1);
      if (got_q.size() > 0) check("timeout_byte", got_q[0], 8'hEF);
      check("timeout_push", push_seen, 0);
      cmd_q = '{8'h02};
      run_cmd(-1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
